// File: rtl/aes_pkg.sv
// AES-128 shared definitions: width constants, round constants, S-box
// (computed as GF(2^8) inverse followed by the affine map), RotWord/SubWord
// helpers and the inverse key schedule state type.
package aes_pkg;

  localparam int unsigned AES_R  = 10;
  localparam int unsigned AES_N  = 128;
  localparam int unsigned AES_RW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    REV  = 2'd2,
    FIN  = 2'd3
  } state_e;

  localparam logic [7:0] RCON [0:9] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Round constant placed in the top byte of a word; zero outside 0..9.
  function automatic logic [31:0] rcon_word(input logic [3:0] idx);
    logic [31:0] w;
    if (idx < 4'd10) begin
      w = {RCON[idx], 24'h000000};
    end else begin
      w = 32'h00000000;
    end
    return w;
  endfunction

  // Multiplication in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    acc = 8'h00;
    aa  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) begin
        acc = acc ^ aa;
      end else begin
        acc = acc;
      end
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  // Multiplicative inverse as x^254 (maps 0 to 0, as the S-box needs).
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    localparam logic [7:0] EXP = 8'hfe;
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = x;
    for (int i = 0; i < 8; i++) begin
      if (EXP[i]) begin
        r = gf_mul(r, p);
      end else begin
        r = r;
      end
      p = gf_mul(p, p);
    end
    return r;
  endfunction

  // Forward AES S-box.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^
           {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] rotword(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

endpackage

// File: rtl/aes_subword.sv
// Combinational SubWord: four parallel forward S-box lookups on a 32-bit word.
module aes_subword
  import aes_pkg::*;
(
  input  logic [31:0] i_word,
  output logic [31:0] o_word
);

  // Substitute each byte independently.
  always_comb begin
    o_word = {sbox(i_word[31:24]), sbox(i_word[23:16]),
              sbox(i_word[15:8]),  sbox(i_word[7:0])};
  end

endmodule

// File: rtl/inv_keyexpansion.sv
// AES-128 inverse key schedule. Expands the cipher key forward to the
// round-10 key, then walks backwards one round key per handshake so the
// inverse cipher receives keys 10..0 without a key storage array.
// Optional round-10 key cache: define INVKEY_CACHE_EN.
module inv_keyexpansion
  import aes_pkg::*;
#(
  parameter int R = AES_R,
  parameter int N = AES_N
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [N-1:0]             key_i,
  output logic                     busy,
  output logic [N-1:0]             key_o,
  output logic [$clog2(R+1)-1:0]   roundnum,
  output logic                     key_valid,
  input  logic                     key_ready,
  output logic                     done
);

  localparam int RNW = $clog2(R+1);
  localparam logic [RNW-1:0] RN_LAST = RNW'(R);

  state_e           r_state;
  logic [N-1:0]     r_key;
  logic [3:0]       r_cnt;
  logic [RNW-1:0]   r_rn;
  logic             r_valid;
  logic             r_busy;
  logic             r_done;

  state_e           w_state_nxt;
  logic [N-1:0]     w_key_nxt;
  logic [3:0]       w_cnt_nxt;
  logic [RNW-1:0]   w_rn_nxt;
  logic             w_valid_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;

  logic [31:0]      w_w0, w_w1, w_w2, w_w3;
  logic [31:0]      w_rev_w3;
  logic [31:0]      w_sw_in;
  logic [31:0]      w_sw_out;
  logic [N-1:0]     w_fwd_key;
  logic [N-1:0]     w_rev_key;
  logic             w_hs;

`ifdef INVKEY_CACHE_EN
  logic [N-1:0]     r_cache_key;
  logic [N-1:0]     r_cache_r10;
  logic             r_cache_vld;
  logic [N-1:0]     w_cache_key_nxt;
  logic [N-1:0]     w_cache_r10_nxt;
  logic             w_cache_vld_nxt;
`endif

  assign w_w0     = r_key[127:96];
  assign w_w1     = r_key[95:64];
  assign w_w2     = r_key[63:32];
  assign w_w3     = r_key[31:0];
  assign w_rev_w3 = w_w3 ^ w_w2;
  assign w_hs     = r_valid & key_ready;

  // Share one SubWord between the forward step (w3) and the reverse step (w3').
  always_comb begin
    if (r_state == REV) begin
      w_sw_in = rotword(w_rev_w3);
    end else begin
      w_sw_in = rotword(w_w3);
    end
  end

  aes_subword u_subword (
    .i_word (w_sw_in),
    .o_word (w_sw_out)
  );

  // Forward and reverse single-round key transforms.
  always_comb begin
    logic [31:0] t;
    logic [31:0] f0, f1, f2, f3;
    t  = w_sw_out ^ rcon_word(r_cnt);
    f0 = w_w0 ^ t;
    f1 = w_w1 ^ f0;
    f2 = w_w2 ^ f1;
    f3 = w_w3 ^ f2;
    w_fwd_key = {f0, f1, f2, f3};
    w_rev_key = {w_w0 ^ w_sw_out ^ rcon_word(4'(r_rn - 4'd1)),
                 w_w1 ^ w_w0, w_w2 ^ w_w1, w_rev_w3};
  end

  // Next-state and next-output logic for the IDLE/FWD/REV/FIN sequence.
  always_comb begin
    w_state_nxt = r_state;
    w_key_nxt   = r_key;
    w_cnt_nxt   = r_cnt;
    w_rn_nxt    = r_rn;
    w_valid_nxt = r_valid;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
`ifdef INVKEY_CACHE_EN
    w_cache_key_nxt = r_cache_key;
    w_cache_r10_nxt = r_cache_r10;
    w_cache_vld_nxt = r_cache_vld;
`endif
    case (r_state)
      IDLE: begin
        w_valid_nxt = 1'b0;
        if (start) begin
          w_key_nxt   = key_i;
          w_cnt_nxt   = 4'd0;
          w_busy_nxt  = 1'b1;
          w_state_nxt = FWD;
`ifdef INVKEY_CACHE_EN
          if (r_cache_vld && (key_i == r_cache_key)) begin
            w_key_nxt   = r_cache_r10;
            w_rn_nxt    = RN_LAST;
            w_valid_nxt = 1'b1;
            w_state_nxt = REV;
          end else begin
            w_cache_key_nxt = key_i;
            w_cache_vld_nxt = 1'b0;
          end
`endif
        end else begin
          w_busy_nxt = 1'b0;
        end
      end
      FWD: begin
        w_key_nxt = w_fwd_key;
        if (r_cnt == 4'd9) begin
          w_rn_nxt    = RN_LAST;
          w_valid_nxt = 1'b1;
          w_state_nxt = REV;
`ifdef INVKEY_CACHE_EN
          w_cache_r10_nxt = w_fwd_key;
          w_cache_vld_nxt = 1'b1;
`endif
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      REV: begin
        if (w_hs) begin
          if (r_rn == '0) begin
            w_valid_nxt = 1'b0;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
            w_state_nxt = FIN;
          end else begin
            w_key_nxt = w_rev_key;
            w_rn_nxt  = r_rn - 4'd1;
          end
        end else begin
          w_key_nxt = r_key;
        end
      end
      FIN: begin
        w_valid_nxt = 1'b0;
        w_busy_nxt  = 1'b0;
        w_state_nxt = IDLE;
      end
      default: begin
        w_valid_nxt = 1'b0;
        w_busy_nxt  = 1'b0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_key   <= '0;
      r_cnt   <= 4'd0;
      r_rn    <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_key   <= w_key_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rn    <= w_rn_nxt;
      r_valid <= w_valid_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

`ifdef INVKEY_CACHE_EN
  // Cipher key / round-10 key cache; reset only clears the valid bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cache_vld <= 1'b0;
      r_cache_key <= r_cache_key;
      r_cache_r10 <= r_cache_r10;
    end else begin
      r_cache_vld <= w_cache_vld_nxt;
      r_cache_key <= w_cache_key_nxt;
      r_cache_r10 <= w_cache_r10_nxt;
    end
  end
`endif

  assign busy      = r_busy;
  assign key_o     = r_key;
  assign roundnum  = r_rn;
  assign key_valid = r_valid;
  assign done      = r_done;

endmodule

// File: tb/tb_inv_keyexpansion.sv
// Self-checking bench for inv_keyexpansion: table of known FIPS-197 round
// keys plus randomized keys and ready patterns checked against a standard
// word-array key expansion model. Cache expectations follow INVKEY_CACHE_EN.
module tb_inv_keyexpansion;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] key_i;
  logic         busy;
  logic [127:0] key_o;
  logic [3:0]   roundnum;
  logic         key_valid;
  logic         key_ready;
  logic         done;

  always #5 clk = ~clk;

  inv_keyexpansion dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .key_i     (key_i),
    .busy      (busy),
    .key_o     (key_o),
    .roundnum  (roundnum),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .done      (done)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [127:0] exp_rk [0:10];
  logic [127:0] obs    [0:10];
  logic [127:0] m_cache_key = 128'h0;
  logic         m_cache_vld = 1'b0;

  localparam logic [127:0] SROWS [0:15] = '{
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] m_sbox(input logic [7:0] x);
    logic [127:0] row;
    row = SROWS[x[7:4]];
    return row[127 - 8*int'(x[3:0]) -: 8];
  endfunction

  function automatic logic [7:0] m_xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Textbook expansion into 44 words; round key r is words 4r..4r+3.
  task automatic model_expand(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {m_sbox(t[31:24]), m_sbox(t[23:16]), m_sbox(t[15:8]), m_sbox(t[7:0])};
        t[31:24] = t[31:24] ^ rc;
        rc = m_xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic int lat_for(input logic [127:0] k);
`ifdef INVKEY_CACHE_EN
    if (m_cache_vld && (k == m_cache_key)) return 1;
`endif
    return 11;
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_cache_vld = 1'b0;
  endtask

  // One full request. mode 0: ready tied high; mode 1: 3 stall cycles at
  // round 10 then random ready. abort_rn >= 0 resets when that round shows.
  // busy_start: a second start with k2 at cycle 5 which must be ignored.
  task automatic run_key(input logic [127:0] k, input int mode, input int abort_rn,
                         input bit busy_start, input logic [127:0] k2);
    int cyc, idx, stall, guard, lat;
    lat = lat_for(k);
    model_expand(k);
    key_i = k;
    start = 1'b1;
    key_ready = 1'b1;
    step();
    start = 1'b0;
    cyc = 1;
    chk("busy_after_start", {127'b0, busy}, 128'd1);
    while (!key_valid && cyc < 40) begin
      start = busy_start && (cyc == 5);
      if (start) key_i = k2;
      step();
      start = 1'b0;
      cyc++;
    end
    chk("first_valid_cycle", 128'(cyc), 128'(lat));
    if (lat == 11) begin
      m_cache_key = k;
      m_cache_vld = 1'b1;
    end
    idx = 10; stall = 0; guard = 0;
    while (idx >= 0 && guard < 200) begin
      if (abort_rn >= 0 && roundnum == 4'(abort_rn)) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
        m_cache_vld = 1'b0;
        chk("abort_valid", {127'b0, key_valid}, 128'd0);
        chk("abort_busy", {127'b0, busy}, 128'd0);
        chk("abort_key", key_o, 128'd0);
        chk("abort_round", 128'(roundnum), 128'd0);
        return;
      end
      if (busy_start && cyc == 5) begin
        start = 1'b1;
        key_i = k2;
      end
      if (mode == 0) key_ready = 1'b1;
      else if (stall < 3) begin key_ready = 1'b0; stall++; end
      else key_ready = 1'($urandom_range(0, 1));
      chk("valid", {127'b0, key_valid}, 128'd1);
      chk("roundnum", 128'(roundnum), 128'(idx));
      chk("round_key", key_o, exp_rk[idx]);
      obs[idx] = key_o;
      if (key_ready) idx--;
      step();
      start = 1'b0;
      guard++;
      cyc++;
    end
    if (guard >= 200) chk("handshake_timeout", 128'(guard), 128'd0);
    chk("fin_valid", {127'b0, key_valid}, 128'd0);
    chk("fin_done", {127'b0, done}, 128'd1);
    chk("fin_busy", {127'b0, busy}, 128'd0);
    if (mode == 0) chk("done_cycle", 128'(cyc), 128'(lat + 11));
    if (mode == 1) begin
      start = 1'b1;
      key_i = ~k;
    end
    step();
    start = 1'b0;
    chk("done_pulse_end", {127'b0, done}, 128'd0);
    chk("idle_not_busy", {127'b0, busy}, 128'd0);
  endtask

  typedef struct {
    logic [127:0] key;
    int           rn;
    logic [127:0] rk;
  } vec_t;

  vec_t vt [0:5];
  logic [127:0] fips_key;
  logic [127:0] rkey;

  initial begin
    fips_key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    vt[0] = '{fips_key, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    vt[1] = '{fips_key,  9, 128'hac7766f319fadc2128d12941575c006e};
    vt[2] = '{fips_key,  1, 128'ha0fafe1788542cb123a339392a6c7605};
    vt[3] = '{fips_key,  0, 128'h2b7e151628aed2a6abf7158809cf4f3c};
    vt[4] = '{128'h0,   10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e};
    vt[5] = '{128'h0,    0, 128'h0};

    rst = 1'b1; start = 1'b0; key_ready = 1'b1; key_i = 128'h0;
    step();
    step();
    chk("reset_valid", {127'b0, key_valid}, 128'd0);
    chk("reset_busy", {127'b0, busy}, 128'd0);
    chk("reset_done", {127'b0, done}, 128'd0);
    chk("reset_key", key_o, 128'd0);
    chk("reset_round", 128'(roundnum), 128'd0);
    rst = 1'b0;
    m_cache_vld = 1'b0;
    step();
    chk("idle_ready_no_effect", {127'b0, key_valid}, 128'd0);

    // Known-answer table; consecutive identical keys also run back-to-back.
    for (int v = 0; v < 6; v++) begin
      run_key(vt[v].key, 0, -1, 1'b0, 128'h0);
      chk("table_round_key", obs[vt[v].rn], vt[v].rk);
    end

    // Backpressure on the FIPS key.
    run_key(fips_key, 1, -1, 1'b0, 128'h0);
    // Second start while busy must be ignored.
    run_key(fips_key, 0, -1, 1'b1, 128'h000102030405060708090a0b0c0d0e0f);
    // Reset in the middle of the reverse phase, then a clean rerun.
    run_key(fips_key, 0, 6, 1'b0, 128'h0);
    run_key(fips_key, 0, -1, 1'b0, 128'h0);
    chk("rerun_round0", obs[0], fips_key);

    // Random keys with random ready, then a repeat of the last one.
    for (int n = 0; n < 4; n++) begin
      rkey = {$urandom, $urandom, $urandom, $urandom};
      run_key(rkey, 1, -1, 1'b0, 128'h0);
    end
    run_key(rkey, 0, -1, 1'b0, 128'h0);
    do_reset();
    run_key(rkey, 0, -1, 1'b0, 128'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/inv_keyexpansion.md
Name: inv_keyexpansion

Overview:
AES-128 inverse key schedule. It accepts the cipher key and emits round keys in decryption order: round 10 first, round 0 last.
- A forward phase expands to the round-10 key, one round per cycle.
- A reverse phase then steps backwards one round key per handshake, with no key storage array.
- It feeds the inverse-cipher datapath, alongside keyexpansion on the encrypt side.

Parameters:
R, 10, number of AES rounds (fixed for AES-128; other values unsupported)
N, 128, key/state bit width

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
start  in  1  request; accepted only when busy=0
key_i  in  N  cipher key; sampled on an accepted start
busy  out  1  high from the cycle after an accepted start until the final handshake
key_o  out  N  current round key; valid only while key_valid=1
roundnum  out  $clog2(R+1)  round index of key_o, counting 10 down to 0
key_valid  out  1  key_o/roundnum valid
key_ready  in  1  consumer accepts key_o when key_valid && key_ready
done  out  1  one-cycle pulse after the round-0 key handshake

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE; key_o=0, roundnum=0, key_valid=0, busy=0, done=0.
  - Cache (optional feature) invalidated.
  - Reset mid-operation aborts immediately; no partial keys are emitted afterwards.
- States: IDLE, FWD, REV, FIN.
- IDLE:
  - start=1 latches key_i into the key register, sets the round counter to 0, enters FWD, busy=1 next cycle.
  - start while busy is ignored (no queueing).
- FWD: each cycle the key register becomes the next forward round key, using words w0..w3 (w0 = bits [127:96]):
  - t = SubWord(RotWord(w3)) ^ rcon[cnt]
  - w0' = w0^t, w1' = w1^w0', w2' = w2^w1', w3' = w3^w2'
  - After 10 cycles (cnt 0..9) the register holds the round-10 key; go to REV with roundnum=10.
- REV:
  - key_valid=1; key_o = register, held stable while key_ready=0.
  - On handshake with roundnum>0, next cycle:
    - w3' = w3^w2, w2' = w2^w1, w1' = w1^w0
    - w0' = w0 ^ SubWord(RotWord(w3')) ^ rcon[roundnum-1]
    - roundnum decrements.
  - On handshake with roundnum=0: key_valid drops next cycle, go to FIN.
- FIN: done=1 for one cycle, busy=0, return to IDLE. start during FIN is ignored.
- Latency (key_ready tied high):
  - start accepted at cycle 0 → first key_valid at cycle 11.
  - 11 keys on cycles 11..21; done at cycle 22.
- Back-to-back: start may be accepted in the IDLE cycle immediately following FIN.
- roundnum wrap: never decrements below 0. FWD cnt never exceeds 9.
- SubWord uses the AES forward S-box only (no inverse S-box in this block).
- key_ready asserted outside REV has no effect.

Optional Feature:
Macro INVKEY_CACHE_EN.
- Defined:
  - Holds the last cipher key and its round-10 key plus a valid bit.
  - The valid bit is set on completion of FWD and cleared on reset.
  - An accepted start whose key_i equals the cached key with valid=1 skips FWD and loads the cached round-10 key directly into REV: first key_valid at cycle 1.
  - A mismatching key runs FWD normally and overwrites the cache.
- Undefined: no cache registers; every start runs FWD (11-cycle latency).

Decomposition:
- Package aes_pkg holds:
  - rcon constant array [0:9];
  - the sbox function and rotword/subword functions;
  - the state enum typedef (IDLE, FWD, REV, FIN);
  - the AES-128 width constants.
- One sub-module, aes_subword: 32-bit combinational SubWord built from four S-box lookups.
  - A single instance is shared by FWD and REV, muxing its input between w3 (FWD) and the reverse-step w3' (REV).

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, key_ready=1 → key_valid first at cycle 11, then:
  - key_o sequence d014f9a8c9ee2589e13f0cc8b6630ca6 (roundnum 10), ac7766f319fadc2128d12941575c006e (9), …, a0fafe1788542cb123a339392a6c7605 (1), 2b7e151628aed2a6abf7158809cf4f3c (0);
  - done at cycle 22.
- Backpressure: same key, key_ready low for 3 cycles while roundnum=10, then a random ready pattern → key_o/roundnum held stable while stalled; all 11 keys delivered exactly once, in order.
- Start while busy: second start with key 000102030405060708090a0b0c0d0e0f at cycle 5 → ignored; output sequence is that of the first key only.
- Reset mid-REV: rst at roundnum=6 → next cycle key_valid=0, busy=0, key_o=0, roundnum=0. A subsequent start produces the full sequence from round 10.
- All-zero key → round-10 key b4ef5bcb3e92e21123e951cf6f8f188e, round 0 = 0.
- INVKEY_CACHE_EN: repeat the FIPS-197 start after done → first key_valid at cycle 1 and an identical sequence. A different key → 11-cycle latency. A repeat after rst → 11-cycle latency.
